// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin arbiter in front of a single registered adder.
// Requesters present operand pairs; one is granted per cycle when the result
// slot is empty or being drained, and the sum is held until the consumer takes it.
module shared_adder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDTH-1:0]           resp_sum,
    output logic [15:0]                op_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_nxt;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    logic             grant_found;
    logic             can_accept;
    logic             accept;
    logic             drain;
    int unsigned      idx;
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] sum_c;

    // Unpack the flat operand buses into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(rr_ptr) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign drain      = resp_valid && resp_ready;
    assign can_accept = (state == EMPTY) || drain;
    assign sum_c      = a_arr[grant_id] + b_arr[grant_id];
    assign rr_nxt     = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Accept strobe goes only to the granted requester, and never during reset
    always_comb begin
        req_ready = '0;
        if (!reset && can_accept && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Next state: a new accept always leaves the slot full, a bare drain empties it
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if (drain) begin
            state_nxt = EMPTY;
        end
    end

    // State register; resp_valid mirrors the FULL state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == FULL);
        end
    end

    // Result slot and round-robin pointer load on accept only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_sum <= '0;
            resp_id  <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            resp_sum <= sum_c;
            resp_id  <= grant_id;
            rr_ptr   <= rr_nxt;
        end
    end

    // Completed response handshakes, free-running and wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (drain) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
